// File: rtl/dmem_pkg.sv
// Shared widths and FSM state encoding for the line-wide data memory model.
package dmem_pkg;
  localparam int LINE_W = 128;
  localparam int BUSY_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_delay_cnt.sv
// Loadable down-counter; saturates at zero, flags zero/one for the access FSM.
module dmem_delay_cnt
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BUSY_W-1:0] load_val_i,
  input  logic              en_i,
  output logic [BUSY_W-1:0] cnt_o,
  output logic              zero_o,
  output logic              one_o
);

  logic [BUSY_W-1:0] cnt_q;
  logic [BUSY_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - BUSY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == BUSY_W'(1));

endmodule

// File: rtl/dmem_line_bank.sv
// Line-wide main-memory model: edge-triggered read/write, done LATENCY cycles after accept.
// DMEM_RANGE_CHECK_EN: requests with non-zero address bits above the line index raise err_mem.
module dmem_line_bank
  import dmem_pkg::*;
#(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_mem,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [LINE_W-1:0] data_in_mem,
  output logic [LINE_W-1:0] data_out_mem,
  output logic              Stall_mem,
  output logic              done_mem,
  output logic [BUSY_W-1:0] busy,
  output logic              err_mem
);

  localparam int DEPTH = 2 ** LINE_IDX_W;

  logic [LINE_W-1:0]     mem [DEPTH];

  state_e                state_q, state_d;
  logic [LINE_IDX_W-1:0] idx_q, idx_d;
  logic                  op_wr_q, op_wr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W-1:0]     dout_q, dout_d;
  logic                  err_q, err_d;
  logic                  rd_q, wr_q;

  logic                  start_rd, start_wr, range_bad;
  logic                  cnt_load, cnt_en, cnt_zero, cnt_one;
  logic                  mem_we;
  logic                  unused_sig;

  assign start_rd = rd_mem & ~rd_q;
  assign start_wr = wr_mem & ~wr_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign range_bad  = |addr_mem[31:LINE_IDX_W+4];
  assign unused_sig = ^{addr_mem[3:0], cnt_zero};
`else
  assign range_bad  = 1'b0;
  assign unused_sig = ^{addr_mem[31:LINE_IDX_W+4], addr_mem[3:0], cnt_zero};
`endif

  dmem_delay_cnt u_delay_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (BUSY_W'(LATENCY)),
    .en_i       (cnt_en),
    .cnt_o      (busy),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_wr_d  = op_wr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rd && start_wr) begin
          err_d = 1'b1;
        end else if ((start_rd || start_wr) && range_bad) begin
          err_d = 1'b1;
        end else if (start_rd || start_wr) begin
          state_d  = S_ACCESS;
          idx_d    = addr_mem[LINE_IDX_W+3:4];
          op_wr_d  = start_wr;
          wdata_d  = data_in_mem;
          cnt_load = 1'b1;
        end
      end
      S_ACCESS: begin
        cnt_en = 1'b1;
        // The array is touched only on the final ACCESS edge, so a reset before it aborts cleanly.
        if (cnt_one) begin
          state_d = S_DONE;
          if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[idx_q];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_wr_q <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_wr_q <= op_wr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      rd_q    <= rd_mem;
      wr_q    <= wr_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign data_out_mem = dout_q;
  assign Stall_mem    = (state_q != S_IDLE);
  assign done_mem     = (state_q == S_DONE);
  assign err_mem      = err_q;

endmodule

// File: tb/tb_dmem_line_bank.sv
// Scoreboard bench: driver pushes expected completions, monitor pops them on done/err pulses.
module tb_dmem_line_bank;
  localparam int LIW = 8;
  localparam int LAT = 4;
  localparam int NLINES = 256;

  logic         clk;
  logic         rst;
  logic [31:0]  addr_mem;
  logic         rd_mem;
  logic         wr_mem;
  logic [127:0] data_in_mem;
  logic [127:0] data_out_mem;
  logic         Stall_mem;
  logic         done_mem;
  logic [3:0]   busy;
  logic         err_mem;

  dmem_line_bank #(.LINE_IDX_W(LIW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_mem     (addr_mem),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .data_in_mem  (data_in_mem),
    .data_out_mem (data_out_mem),
    .Stall_mem    (Stall_mem),
    .done_mem     (done_mem),
    .busy         (busy),
    .err_mem      (err_mem)
  );

  typedef struct {
    bit           is_err;
    bit           is_rd;
    logic [127:0] data;
  } exp_t;

  exp_t         expq[$];
  logic [127:0] model [NLINES];
  logic [127:0] last_rd;
  int           checks = 0;
  int           errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every completion or error pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_mem === 1'b1 || err_mem === 1'b1) begin
        if (expq.size() == 0) begin
          chk("spurious_out", {126'd0, done_mem, err_mem}, 128'd0);
        end else begin
          e = expq.pop_front();
          chk("out_is_err", {127'd0, err_mem}, {127'd0, e.is_err});
          chk("out_is_done", {127'd0, done_mem}, {127'd0, !e.is_err});
          if (!e.is_err && e.is_rd) chk("rd_data", data_out_mem, e.data);
        end
      end
    end
  end

  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [127:0] d, input int hold, input bit intrude,
                       input int rst_at);
    int   idx;
    int   span;
    bit   legal;
    bit   bad_rng;
    exp_t e;
    idx     = int'((addr >> 4) % NLINES);
    bad_rng = (addr >> (LIW + 4)) != 0;
`ifdef DMEM_RANGE_CHECK_EN
    legal = !(rd && wr) && !bad_rng;
`else
    legal = !(rd && wr);
`endif
    @(negedge clk);
    addr_mem    = addr;
    data_in_mem = d;
    rd_mem      = rd;
    wr_mem      = wr;
    if (rst_at < 0) begin
      e.is_err = !legal;
      e.is_rd  = rd;
      e.data   = model[idx];
      expq.push_back(e);
    end
    span = legal ? LAT + 1 : 1;
    if (hold > span) span = hold;
    for (int k = 0; k <= span; k++) begin
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_dout", data_out_mem, 128'd0);
        chk("rst_stall", {127'd0, Stall_mem}, 128'd0);
        chk("rst_done", {127'd0, done_mem}, 128'd0);
        chk("rst_busy", {124'd0, busy}, 128'd0);
        chk("rst_err", {127'd0, err_mem}, 128'd0);
        rst     = 1'b0;
        last_rd = '0;
        break;
      end
      if (legal) begin
        chk("busy", {124'd0, busy}, (k < LAT) ? 128'(LAT - k) : 128'd0);
        chk("stall", {127'd0, Stall_mem}, {127'd0, k <= LAT});
        chk("done_time", {127'd0, done_mem}, {127'd0, k == LAT});
        if (wr && k == LAT) chk("wr_keeps_dout", data_out_mem, last_rd);
      end else begin
        chk("err_stall", {127'd0, Stall_mem}, 128'd0);
        chk("err_busy", {124'd0, busy}, 128'd0);
        chk("err_time", {127'd0, err_mem}, {127'd0, k == 0});
      end
      if (k == hold - 1) begin
        rd_mem = 1'b0;
        wr_mem = 1'b0;
      end
      if (intrude && k == 1) begin
        wr_mem      = 1'b1;
        data_in_mem = ~d;
      end
      if (rst_at >= 0 && k == rst_at) begin
        rst    = 1'b1;
        rd_mem = 1'b0;
        wr_mem = 1'b0;
      end
    end
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    if (legal && rst_at < 0) begin
      if (rd) last_rd = model[idx];
      else    model[idx] = d;
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pat;
    logic [31:0]  a;
    logic         r;
    logic         w;
    pat         = 128'h11111111_22222222_33333333_AAAAAAAA;
    rst         = 1'b1;
    rd_mem      = 1'b0;
    wr_mem      = 1'b0;
    addr_mem    = '0;
    data_in_mem = '0;
    last_rd     = '0;
    for (int i = 0; i < NLINES; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_dout", data_out_mem, 128'd0);
    chk("reset_stall", {127'd0, Stall_mem}, 128'd0);
    chk("reset_done", {127'd0, done_mem}, 128'd0);
    chk("reset_busy", {124'd0, busy}, 128'd0);
    chk("reset_err", {127'd0, err_mem}, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 32'(i << 4), rand_line(), 2, 1'b0, -1);

    do_op(1'b0, 1'b1, 32'h0000_0120, pat, 1, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0000_0120, '0, 2, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0000_0030, '0, 12, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0000_0070, '0, 8, 1'b1, -1);
    do_op(1'b1, 1'b0, 32'h0000_0070, '0, 1, 1'b0, -1);
    do_op(1'b1, 1'b1, 32'h0000_0040, rand_line(), 2, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0000_0040, '0, 1, 1'b0, -1);
    do_op(1'b0, 1'b1, 32'h0000_0050, rand_line(), 6, 1'b0, 2);
    do_op(1'b1, 1'b0, 32'h0000_0050, '0, 1, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0001_0000, '0, 1, 1'b0, -1);
    do_op(1'b1, 1'b0, 32'h0000_0000, '0, 1, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 15) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << (LIW + 4));
      r = 1'($urandom_range(0, 1));
      w = !r;
      if ($urandom_range(0, 7) == 0) begin
        r = 1'b1;
        w = 1'b1;
      end
      do_op(r, w, a, rand_line(), $urandom_range(1, 8), 1'($urandom_range(0, 4) == 0), -1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(expq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
